// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the asynchronous SRAM access controller:
// FSM encoding, RAM timing constants and wait-state legality bounds.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // RAM datasheet access times in ns
  localparam int T_ACC_ADDR = 26;
  localparam int T_ACC_CS   = 9;

  // Legal range of wait states (CS_BAR low cycles); counter is 4 bits
  localparam int MIN_WAIT = 1;
  localparam int MAX_WAIT = 15;

  // Counter preload so that STROBE lasts exactly w cycles
  function automatic logic [3:0] wait_load(input int w);
    return 4'(w - 1);
  endfunction

endpackage

// File: rtl/ram_access_ctrl.sv
// Synchronous front end for a 256x8 asynchronous SRAM. Sequences address
// setup, a WAIT_CYCLES-long chip-select strobe and a hold cycle, capturing
// read data and pulsing ACK. Every output comes straight from a flop.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 3
) (
  input  logic       CLK,
  input  logic       RST_BAR,
  input  logic       REQ,
  input  logic       WR,
  input  logic [7:0] ADDR,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA,
  output logic       ACK,
  output logic       BUSY,
  output logic [7:0] RAM_A,
  output logic [7:0] RAM_D,
  input  logic [7:0] RAM_O,
  output logic       RAM_CS_BAR,
  output logic       RAM_WE_BAR
);

  localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  if (WAIT_CYCLES < MIN_WAIT || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
    $error("ram_access_ctrl: WAIT_CYCLES out of range 1..15");
  end

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       cs_q, cs_d;
  logic       we_q, we_d;
  logic [7:0] a_q, a_d;
  logic [7:0] d_q, d_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ack_q, ack_d;
  logic       busy_q, busy_d;

  // State and output registers; reset deselects the RAM immediately
  always_ff @(posedge CLK or negedge RST_BAR) begin
    if (!RST_BAR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cs_q    <= 1'b1;
      we_q    <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      a_q     <= a_d;
      d_q     <= d_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic. A/D/WE only move in IDLE or on the
  // HOLD->IDLE edge, both of which have CS_BAR high before and after.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    we_d    = we_q;
    a_d     = a_q;
    d_d     = d_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (REQ) begin
          a_d     = ADDR;
          if (WR) d_d = WDATA;
          we_d    = WR;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cs_d    = 1'b0;
        cnt_d   = WAIT_LOAD;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) rdata_d = RAM_O;
          cs_d    = 1'b1;
          ack_d   = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        we_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign RDATA      = rdata_q;
  assign ACK        = ack_q;
  assign BUSY       = busy_q;
  assign RAM_A      = a_q;
  assign RAM_D      = d_q;
  assign RAM_CS_BAR = cs_q;
  assign RAM_WE_BAR = we_q;

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Synchronous front end for the 8-bit asynchronous static RAM (256 x 8).
- Converts a single-cycle CPU request (REQ/WR/ADDR/WDATA) into a correctly sequenced chip-select/write-enable strobe on the RAM pins.
- Inserts programmable wait states to cover the RAM access time, captures read data into a register and returns a one-cycle ACK.
- Sits between the CPU datapath/bus arbiter and the RAM chip.

Parameters:
- WAIT_CYCLES, 3, clock cycles CS_BAR is held low per access (legal range 1..15). The default covers the RAM's 26 ns access time at a 10 ns clock.

Ports:
- CLK  input  1  system clock, rising-edge
- RST_BAR  input  1  asynchronous active-low reset
- REQ  input  1  access request, sampled only in IDLE
- WR  input  1  1 = write, 0 = read; qualified by REQ
- ADDR  input  8  access address; qualified by REQ
- WDATA  input  8  write data; qualified by REQ and WR
- RDATA  output  8  registered read data
- ACK  output  1  one-cycle completion pulse
- BUSY  output  1  high whenever state != IDLE
- RAM_A  output  8  RAM address pins
- RAM_D  output  8  RAM data-in pins
- RAM_O  input  8  RAM data-out pins (high-Z while deselected)
- RAM_CS_BAR  output  1  RAM chip select, active low
- RAM_WE_BAR  output  1  RAM mode: 1 = write, 0 = read (RAM polarity, valid while CS_BAR low)

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low. All outputs are registered.
- Reset values: state = IDLE; RAM_CS_BAR = 1; RAM_WE_BAR = 0; RAM_A = 0; RAM_D = 0; RDATA = 0; ACK = 0; BUSY = 0; wait counter = 0.
- RAM pin semantics:
  - CS_BAR = 0 with WE_BAR = 1 writes D to A.
  - CS_BAR = 0 with WE_BAR = 0 drives memory[A] on O.
  - CS_BAR = 1 leaves O at high-Z.
- Invariant: RAM_WE_BAR, RAM_A and RAM_D never change on a clock edge where RAM_CS_BAR is 0 or becomes 0. Otherwise a read could turn into a spurious write, or a write could land at the wrong address.
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE:
  - If REQ = 1 at the edge: latch ADDR into RAM_A. If WR = 1, also latch WDATA into RAM_D; otherwise RAM_D keeps its value.
  - Set RAM_WE_BAR = WR and go to SETUP.
  - If REQ = 0: stay in IDLE.
- SETUP: exactly one cycle with CS_BAR = 1 and address/data/WE stable. Next edge sets RAM_CS_BAR = 0, loads the counter with WAIT_CYCLES-1 and goes to STROBE.
- STROBE:
  - CS_BAR stays low for exactly WAIT_CYCLES cycles; the counter decrements each edge.
  - On the edge where the counter is 0: for a read, capture RAM_O into RDATA. Then set RAM_CS_BAR = 1, set ACK = 1 and go to HOLD.
- HOLD:
  - One cycle; ACK = 1 only in this cycle.
  - Next edge: RAM_WE_BAR returns to 0 (CS_BAR is already high), ACK = 0, go to IDLE.
- Latency: for an accept at edge 0, CS_BAR is low from edge 1 to edge 1+WAIT_CYCLES, ACK is high between edges 1+WAIT_CYCLES and 2+WAIT_CYCLES, and RDATA is valid from edge 1+WAIT_CYCLES.
- Throughput: REQ is accepted only in IDLE, so the earliest next accept is edge 3+WAIT_CYCLES (one access per 3+WAIT_CYCLES cycles).
- REQ, WR, ADDR and WDATA are ignored while BUSY = 1; there is no queueing. The requester holds REQ or re-asserts it after ACK.
- RDATA holds its value until the next read completes; writes never modify RDATA.
- Reset mid-access: RAM_CS_BAR goes to 1 asynchronously, and no ACK is issued. If reset hits during STROBE of a write, the addressed location's contents are undefined; all other locations are unaffected.
- WAIT_CYCLES = 1: STROBE lasts a single cycle and the counter is unused but legal.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - the state encoding (2-bit: IDLE = 0, SETUP = 1, STROBE = 2, HOLD = 3);
  - RAM timing constants: T_ACC_ADDR = 26 ns, T_ACC_CS = 9 ns;
  - the MIN_WAIT/MAX_WAIT legality bounds.
- No sub-module: the FSM and the 4-bit wait counter live in one module. The bench supplies its own RAM behavioural model.

Test Plan:
- Reset with RST_BAR held low, then released -> all outputs at their reset values; CS_BAR = 1 throughout; BUSY = 0.
- Write ADDR = 0x3C, WDATA = 0xA5 at WAIT_CYCLES = 3 -> WE_BAR = 1 one cycle before CS_BAR falls; CS_BAR low for exactly 3 cycles; ACK pulses at cycle 5; a later read of 0x3C returns RDATA = 0xA5.
- Read of a never-written location 0x10 -> RDATA = 0xXX, captured at the last STROBE edge; WE_BAR stays 0 for the entire access.
- REQ held high continuously: write 0x01 -> 0x11, then read 0x01 -> accepts spaced exactly 6 cycles apart; RDATA = 0x11; no CS_BAR low edge coincides with any A/WE/D change (assertion-checked).
- RST_BAR pulsed low during the second STROBE cycle of a write to 0x20 -> CS_BAR goes to 1 immediately; no ACK; state = IDLE; a following write/read of 0x21 = 0x5A returns 0x5A.
- WAIT_CYCLES = 1 rebuild: read after write of 0xFF -> 0xC3 -> CS_BAR low for 1 cycle; ACK at cycle 3 after accept; RDATA = 0xC3.
